// File: rtl/bist_fail_log_pkg.sv
// Shared types and constants for the BIST fail-capture log.
// Imported by the interface, the FIFO and the top.
package bist_fail_log_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOG  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int FCNT_W = 8;
    localparam logic [FCNT_W-1:0] FCNT_MAX = 8'd255;

    function automatic int entry_width(input int aw, input int dw);
        return aw + 2 * dw;
    endfunction

endpackage

// File: rtl/bist_fail_log_if.sv
// Compare-strobe, control and readout bundle of the fail log.
// slave is the log side, master is the BIST/diagnostic side.
interface bist_fail_log_if
    import bist_fail_log_pkg::*;
#(
    parameter int data_width = 4,
    parameter int ad_width   = 4
);
    logic                  start;
    logic                  cmp_valid;
    logic [ad_width-1:0]   cmp_addr;
    logic [data_width-1:0] cmp_exp;
    logic [data_width-1:0] cmp_act;
    logic                  bist_done;
    logic                  rd_req;
    logic                  rd_valid;
    logic [ad_width-1:0]   rd_addr;
    logic [data_width-1:0] rd_syn;
    logic [data_width-1:0] rd_act;
    logic [FCNT_W-1:0]     fail_count;
    logic                  overflow;
    logic                  log_done;

    modport slave (
        input  start, cmp_valid, cmp_addr, cmp_exp, cmp_act,
        input  bist_done, rd_req,
        output rd_valid, rd_addr, rd_syn, rd_act,
        output fail_count, overflow, log_done
    );

    modport master (
        output start, cmp_valid, cmp_addr, cmp_exp, cmp_act,
        output bist_done, rd_req,
        input  rd_valid, rd_addr, rd_syn, rd_act,
        input  fail_count, overflow, log_done
    );
endinterface

// File: rtl/bist_fail_log_fail_fifo.sv
// Circular first-word-fall-through FIFO holding failing entries.
// Full/empty come from an extra wrap bit on each pointer.
module fail_fifo #(
    parameter int width = 12,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] one = 1;

    logic [aw:0]      wr_ptr;
    logic [aw:0]      rd_ptr;
    logic [width-1:0] mem [depth];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + one;
            if (do_pop)  rd_ptr <= rd_ptr + one;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[aw-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[aw] != rd_ptr[aw]) &&
                   (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign head  = mem[rd_ptr[aw-1:0]];
endmodule

// File: rtl/bist_fail_log.sv
// BIST fail-capture stage: counts mismatches, logs the first depth
// of them and freezes the log for readout once the run is done.
module bist_fail_log
    import bist_fail_log_pkg::*;
#(
    parameter int data_width = 4,
    parameter int ad_width   = 4,
    parameter int depth      = 4
) (
    input  logic           clk,
    input  logic           rst,
    bist_fail_log_if.slave bus
);
    localparam int ew = entry_width(ad_width, data_width);

    state_t            state;
    state_t            state_nxt;
    logic              mismatch;
    logic              capture;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ew-1:0]     din;
    logic [ew-1:0]     head;
    logic [FCNT_W-1:0] count;
    logic              ovf;
    logic              valid;

    assign mismatch = bus.cmp_valid && (bus.cmp_exp != bus.cmp_act);
    assign capture  = (state == LOG) && !bus.start && mismatch;
    assign push     = capture && !full;
    assign pop      = (state == HOLD) && !bus.start &&
                      bus.rd_req && !empty;
    assign din      = {bus.cmp_addr, bus.cmp_exp ^ bus.cmp_act,
                       bus.cmp_act};

    fail_fifo #(
        .width (ew),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.start),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.start) begin
            state_nxt = LOG;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                LOG:     if (bus.bist_done) state_nxt = HOLD;
                HOLD:    state_nxt = HOLD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.start) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (capture) begin
            if (count != FCNT_MAX) count <= count + 1'b1;
            if (full)              ovf   <= 1'b1;
        end
    end

    // Head data is masked so stale RAM never reaches the outputs.
    assign valid          = (state == HOLD) && !empty;
    assign bus.rd_valid   = valid;
    assign bus.rd_addr    = valid ? head[ew-1 -: ad_width] : '0;
    assign bus.rd_syn     = valid ? head[2*data_width-1 -: data_width] : '0;
    assign bus.rd_act     = valid ? head[data_width-1:0] : '0;
    assign bus.fail_count = count;
    assign bus.overflow   = ovf;
    assign bus.log_done   = (state == HOLD);
endmodule

// File: doc/bist_fail_log.md
# bist_fail_log

Fail-capture stage that sits directly downstream of the memory BIST controller's compare logic. It consumes every per-address compare strobe produced during a BIST run and records up to `depth` mismatching entries (address, expected, actual) in a small first-word-fall-through log. It counts all mismatches and freezes the log when the BIST reports done, so diagnostics can drain the failing addresses after a run instead of seeing only a single `fail` bit.

## Interface
- `data_width`, 4, memory word width
- `ad_width`, 4, memory address width
- `depth`, 4, log entries (power of two, ≥2)
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse, same pulse that starts the BIST; clears log, begins capture
- `cmp_valid`  in  1  compare strobe from BIST read phase
- `cmp_addr`  in  ad_width  address being compared
- `cmp_exp`  in  data_width  expected data
- `cmp_act`  in  data_width  data read from memory
- `bist_done`  in  1  BIST run complete (level or pulse)
- `rd_req`  in  1  pop head entry
- `rd_valid`  out  1  head entry present and readable
- `rd_addr`  out  ad_width  head entry address
- `rd_syn`  out  data_width  head entry syndrome, exp XOR act
- `rd_act`  out  data_width  head entry actual data
- `fail_count`  out  8  mismatches this run, saturating at 255
- `overflow`  out  1  at least one mismatch was dropped (log full)
- `log_done`  out  1  capture closed, log frozen for readout

## Operation
- States: IDLE, LOG, HOLD. Reset → IDLE.
- IDLE: ignores `cmp_valid`, `bist_done`, `rd_req`. `start` → LOG.
- Any state, `start`=1: clear FIFO pointers, `fail_count`, `overflow`, `log_done`; next state LOG. `start` beats every other input in the same cycle (compare in that cycle dropped, read ignored).
- LOG: mismatch = `cmp_valid` & (`cmp_exp` != `cmp_act`). On mismatch: `fail_count` += 1 (saturate at 255); if not full, push {addr, exp^act, act}; if full, drop entry and set `overflow` (sticky until `start`/reset). Matching compares do nothing.
- LOG, `bist_done`=1: a mismatch in the same cycle is still logged/counted; next state HOLD.
- HOLD: `log_done`=1; compares ignored. `rd_valid` = FIFO not empty. `rd_req` & `rd_valid` pops head; `rd_req` while empty ignored, no underflow. `bist_done` ignored.
- FIFO: circular, `depth` entries, pointers wrap modulo `depth`, full/empty via extra pointer bit. No push/pop overlap possible (push only in LOG, pop only in HOLD).
- Reset mid-run: all state discarded immediately.

## Timing
- Reset values: `rd_valid`=0, `rd_addr`=0, `rd_syn`=0, `rd_act`=0, `fail_count`=0, `overflow`=0, `log_done`=0.
- Mismatch sampled at edge N: `fail_count`/`overflow` updated after edge N; entry readable in HOLD.
- `bist_done` sampled at edge N: `log_done`=1 and `rd_valid` (if entries) after edge N.
- Read data is first-word-fall-through: `rd_addr/rd_syn/rd_act` show head whenever `rd_valid`=1; pop at edge N presents next entry after edge N (one entry per cycle with `rd_req` held high).
- `start` at edge N: outputs at reset values (except state LOG) after edge N.
- All outputs registered or decoded from registered state; no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding (IDLE/LOG/HOLD), `FCNT_W`=8, `FCNT_MAX`=255, entry width = `ad_width`+2·`data_width`.
- One sub-module `fail_fifo`: parameterised synchronous FIFO (push, pop, clr, full, empty, FWFT head). Control FSM, mismatch detect, and counter live in `bist_fail_log`.

## Test plan
- Reset then clean run: `start`, 16 compares exp=act=4'hA, `bist_done` → `fail_count`=0, `rd_valid`=0, `log_done`=1, `overflow`=0.
- Two fails: mismatches at addr 3 (exp 5, act 7) and addr 9 (exp F, act 0), `bist_done` → first entry addr 3/syn 2/act 7, pop → addr 9/syn F/act 0, pop → `rd_valid`=0, `fail_count`=2.
- Overflow: 6 mismatches at addrs 0–5 with depth 4 → `fail_count`=6, `overflow`=1, log holds addrs 0–3 in order.
- Simultaneous events: `bist_done` with mismatch at addr E same cycle → entry logged, `log_done`=1 next cycle; `start` with mismatch same cycle → nothing logged, `fail_count`=0.
- Restart/readout edge: in HOLD with 2 entries, `rd_req` on empty after draining → no change; new `start` → `log_done`=0, `fail_count`=0, `rd_valid`=0.
- Async reset mid-LOG (3 entries logged, `rst` low between edges) → all outputs 0 immediately, IDLE; compares ignored until `start`.
